// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file command initiator.
// RF_MASTER_SWAP_EN adds the SWAP states to the state type.
package rf_pkg;

  localparam int RF_DW = 8;
  localparam int RF_AW = 4;

  localparam logic RF_READ  = 1'b1;
  localparam logic RF_WRITE = 1'b0;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_COPY  = 2'b10;
  localparam logic [1:0] OP_SWAP  = 2'b11;

  typedef enum logic [3:0] {
    IDLE,
    WR,
    RD,
    RWAIT,
    RSP,
    CP_RD,
    CP_WAIT,
    CP_WR
`ifdef RF_MASTER_SWAP_EN
    ,
    SW_RA,
    SW_RB,
    SW_CB,
    SW_WA,
    SW_WB
`endif
  } rf_state_e;

endpackage

// File: rtl/rf_master.sv
// Command-driven initiator for the register file: WRITE, READ, COPY and SWAP.
// SWAP is built only when RF_MASTER_SWAP_EN is defined; otherwise op 11 pulses err.
module rf_master
  import rf_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid holds its payload stable until that edge and never depends on ready.
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [RF_AW-1:0]  cmd_dst,
  input  logic [RF_AW-1:0]  cmd_src,
  input  logic [RF_DW-1:0]  cmd_imm,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RF_DW-1:0]  rsp_data,
  output logic              err,
  output logic              rf_enb,
  output logic              rf_r_w,
  output logic [RF_AW-1:0]  rf_sel,
  output logic [RF_DW-1:0]  rf_wdata,
  input  logic [RF_DW-1:0]  rf_rdata
);

  rf_state_e        state, state_next;
  logic             enb_next;
  logic             r_w_next;
  logic [RF_AW-1:0] sel_next;
  logic [RF_DW-1:0] wdata_next;
  logic             err_next;
  logic [RF_AW-1:0] dst_q;
`ifdef RF_MASTER_SWAP_EN
  logic [RF_AW-1:0] src_q;
  logic [RF_DW-1:0] tmp_a;
`endif

  assign cmd_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Register-file outputs are computed for the state being entered, so they
  // only change on state entry and are stable for the whole state.
  always_comb begin
    state_next = state;
    enb_next   = 1'b0;
    r_w_next   = RF_READ;
    sel_next   = rf_sel;
    wdata_next = rf_wdata;
    err_next   = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_WRITE: begin
              state_next = WR;
              enb_next   = 1'b1;
              r_w_next   = RF_WRITE;
              sel_next   = cmd_dst;
              wdata_next = cmd_imm;
            end
            OP_READ: begin
              state_next = RD;
              enb_next   = 1'b1;
              sel_next   = cmd_dst;
            end
            OP_COPY: begin
              state_next = CP_RD;
              enb_next   = 1'b1;
              sel_next   = cmd_src;
            end
            default: begin
`ifdef RF_MASTER_SWAP_EN
              state_next = SW_RA;
              enb_next   = 1'b1;
              sel_next   = cmd_dst;
`else
              err_next   = 1'b1;
`endif
            end
          endcase
        end
      end
      WR:      state_next = IDLE;
      RD:      state_next = RWAIT;
      RWAIT:   state_next = RSP;
      RSP:     if (rsp_ready) state_next = IDLE;
      CP_RD:   state_next = CP_WAIT;
      CP_WAIT: begin
        // rf_wdata doubles as the copy temp: it captures the source value here.
        state_next = CP_WR;
        enb_next   = 1'b1;
        r_w_next   = RF_WRITE;
        sel_next   = dst_q;
        wdata_next = rf_rdata;
      end
      CP_WR:   state_next = IDLE;
`ifdef RF_MASTER_SWAP_EN
      SW_RA: begin
        state_next = SW_RB;
        enb_next   = 1'b1;
        sel_next   = src_q;
      end
      SW_RB:   state_next = SW_CB;
      SW_CB: begin
        state_next = SW_WA;
        enb_next   = 1'b1;
        r_w_next   = RF_WRITE;
        sel_next   = dst_q;
        wdata_next = rf_rdata;
      end
      SW_WA: begin
        state_next = SW_WB;
        enb_next   = 1'b1;
        r_w_next   = RF_WRITE;
        sel_next   = src_q;
        wdata_next = tmp_a;
      end
      SW_WB:   state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_enb    <= 1'b0;
      rf_r_w    <= RF_READ;
      rf_sel    <= '0;
      rf_wdata  <= '0;
      err       <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      dst_q     <= '0;
    end else begin
      rf_enb    <= enb_next;
      rf_r_w    <= r_w_next;
      rf_sel    <= sel_next;
      rf_wdata  <= wdata_next;
      err       <= err_next;
      rsp_valid <= (state_next == RSP);
      if (state == RWAIT) rsp_data <= rf_rdata;
      if (cmd_valid && cmd_ready) dst_q <= cmd_dst;
    end
  end

`ifdef RF_MASTER_SWAP_EN
  // A's value arrives during SW_RB; B's value goes straight into rf_wdata.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      src_q <= '0;
      tmp_a <= '0;
    end else begin
      if (cmd_valid && cmd_ready) src_q <= cmd_src;
      if (state == SW_RB) tmp_a <= rf_rdata;
    end
  end
`endif

endmodule

// File: tb/tb_rf_master.sv
// Self-checking bench for rf_master with a behavioural register file and a
// command-level model of the register contents.
module tb_rf_master;
  import rf_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_dst = 4'h0;
  logic [3:0] cmd_src = 4'h0;
  logic [7:0] cmd_imm = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       err;
  logic       rf_enb;
  logic       rf_r_w;
  logic [3:0] rf_sel;
  logic [7:0] rf_wdata;
  logic [7:0] rf_rdata = 8'h00;

  logic [7:0] rf_mem [16] = '{default: 8'h00};
  logic [7:0] model [16];
  logic [7:0] exp_q [$];

  int errors = 0;
  int checks = 0;
  int enb_cnt = 0;
  int err_cnt = 0;
  int exp_err = 0;

  rf_master dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_dst(cmd_dst), .cmd_src(cmd_src), .cmd_imm(cmd_imm),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .err(err), .rf_enb(rf_enb), .rf_r_w(rf_r_w), .rf_sel(rf_sel),
    .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
  );

  // clock / reset
  always #5 clk = ~clk;

  // register file with one-cycle registered read; unaffected by rst_n
  always @(posedge clk) begin
    if (rf_enb) begin
      if (rf_r_w == RF_WRITE) rf_mem[rf_sel] <= rf_wdata;
      else rf_rdata <= rf_mem[rf_sel];
    end
  end

  always @(posedge clk) begin
    if (rf_enb) enb_cnt++;
    if (err) err_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time exhausted, required completion");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic issue(input logic [1:0] op, input logic [3:0] dst,
                       input logic [3:0] src, input logic [7:0] imm);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst; cmd_src = src; cmd_imm = imm;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout: cmd_ready=%0b required 1", cmd_ready);
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_idle_timeout: cmd_ready=%0b required 1", name, cmd_ready);
    end
  endtask

  task automatic do_write(input logic [3:0] dst, input logic [7:0] imm);
    issue(OP_WRITE, dst, 4'h0, imm);
    model[dst] = imm;
    wait_idle("write");
  endtask

  task automatic get_rsp(input int delay, input string name);
    int n = 0;
    logic [7:0] exp;
    while (!rsp_valid && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_rsp_timeout: rsp_valid=%0b required 1", name, rsp_valid);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    exp = exp_q.pop_front();
    checks++;
    if (rsp_data !== exp) begin
      errors++;
      $display("FAIL %s_data: rsp_data=%h required %h", name, rsp_data, exp);
    end
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp || cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s_hold: valid=%0b data=%h ready=%0b required 1 %h 0",
                 name, rsp_valid, rsp_data, cmd_ready, exp);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_release: rsp_valid=%0b cmd_ready=%0b required 0 1",
               name, rsp_valid, cmd_ready);
    end
  endtask

  // scenarios
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({cmd_ready, rsp_valid, rsp_data, err, rf_enb, rf_r_w, rf_sel, rf_wdata}
        !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'h0, 8'h00}) begin
      errors++;
      $display("FAIL reset_values: rdy=%0b rv=%0b rd=%h err=%0b enb=%0b rw=%0b sel=%h wd=%h required 1 0 00 0 0 1 0 00",
               cmd_ready, rsp_valid, rsp_data, err, rf_enb, rf_r_w, rf_sel, rf_wdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || rf_enb !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: cmd_ready=%0b rf_enb=%0b required 1 0", cmd_ready, rf_enb);
    end
  endtask

  task automatic test_write();
    issue(OP_WRITE, 4'd3, 4'd0, 8'hA5);
    model[3] = 8'hA5;
    checks++;
    if ({rf_enb, rf_r_w, rf_sel, rf_wdata, cmd_ready} !== {1'b1, 1'b0, 4'd3, 8'hA5, 1'b0}) begin
      errors++;
      $display("FAIL write_e0: enb=%0b rw=%0b sel=%h wd=%h rdy=%0b required 1 0 3 a5 0",
               rf_enb, rf_r_w, rf_sel, rf_wdata, cmd_ready);
    end
    @(negedge clk);
    checks++;
    if (rf_enb !== 1'b0 || rf_r_w !== 1'b1 || cmd_ready !== 1'b1 || rf_mem[3] !== 8'hA5) begin
      errors++;
      $display("FAIL write_e1: enb=%0b rw=%0b rdy=%0b r3=%h required 0 1 1 a5",
               rf_enb, rf_r_w, cmd_ready, rf_mem[3]);
    end
  endtask

  task automatic test_read_backpressure();
    int e;
    do_write(4'd5, 8'h3C);
    exp_q.push_back(model[5]);
    issue(OP_READ, 4'd5, 4'd0, 8'h00);
    checks++;
    if (rf_enb !== 1'b1 || rf_r_w !== 1'b1 || rf_sel !== 4'd5) begin
      errors++;
      $display("FAIL read_e0: enb=%0b rw=%0b sel=%h required 1 1 5", rf_enb, rf_r_w, rf_sel);
    end
    @(negedge clk);
    checks++;
    if (rf_enb !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL read_e1: enb=%0b rsp_valid=%0b required 0 0", rf_enb, rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL read_e2: rsp_valid=%0b required 1", rsp_valid);
    end
    // offer a command while the response is pending; it must not be taken
    e = enb_cnt;
    cmd_valid = 1'b1; cmd_op = OP_WRITE; cmd_dst = 4'd5; cmd_imm = 8'hFF;
    get_rsp(4, "read_bp");
    cmd_valid = 1'b0;
    checks++;
    if (enb_cnt !== e || rf_mem[5] !== 8'h3C) begin
      errors++;
      $display("FAIL read_no_accept: enb_cycles=%0d r5=%h required %0d 3c", enb_cnt, rf_mem[5], e);
    end
    // that command was taken on the IDLE re-entry edge, or not at all
    wait_idle("read_bp");
    @(negedge clk);
    do_write(4'd5, 8'h3C);
  endtask

  task automatic test_copy();
    do_write(4'd2, 8'h11);
    issue(OP_COPY, 4'd7, 4'd2, 8'h00);
    checks++;
    if (rf_enb !== 1'b1 || rf_r_w !== 1'b1 || rf_sel !== 4'd2) begin
      errors++;
      $display("FAIL copy_e0: enb=%0b rw=%0b sel=%h required 1 1 2", rf_enb, rf_r_w, rf_sel);
    end
    @(negedge clk);
    checks++;
    if (rf_enb !== 1'b0) begin
      errors++;
      $display("FAIL copy_e1: enb=%0b required 0", rf_enb);
    end
    @(negedge clk);
    checks++;
    if ({rf_enb, rf_r_w, rf_sel, rf_wdata, cmd_ready} !== {1'b1, 1'b0, 4'd7, 8'h11, 1'b0}) begin
      errors++;
      $display("FAIL copy_e2: enb=%0b rw=%0b sel=%h wd=%h rdy=%0b required 1 0 7 11 0",
               rf_enb, rf_r_w, rf_sel, rf_wdata, cmd_ready);
    end
    @(negedge clk);
    model[7] = model[2];
    checks++;
    if (cmd_ready !== 1'b1 || rf_mem[7] !== model[7]) begin
      errors++;
      $display("FAIL copy_e3: rdy=%0b r7=%h required 1 %h", cmd_ready, rf_mem[7], model[7]);
    end
    exp_q.push_back(model[7]);
    issue(OP_READ, 4'd7, 4'd0, 8'h00);
    get_rsp(1, "copy_read");
    do_write(4'd4, 8'h5A);
    issue(OP_COPY, 4'd4, 4'd4, 8'h00);
    wait_idle("copy_same");
    checks++;
    if (rf_mem[4] !== 8'h5A) begin
      errors++;
      $display("FAIL copy_same: r4=%h required 5a", rf_mem[4]);
    end
  endtask

  task automatic test_swap();
    int e;
    logic [7:0] t;
    do_write(4'd1, 8'h01);
    do_write(4'd9, 8'h99);
    e = enb_cnt;
    issue(OP_SWAP, 4'd1, 4'd9, 8'h00);
`ifdef RF_MASTER_SWAP_EN
    checks++;
    if (rf_enb !== 1'b1 || rf_r_w !== 1'b1 || rf_sel !== 4'd1) begin
      errors++;
      $display("FAIL swap_e0: enb=%0b rw=%0b sel=%h required 1 1 1", rf_enb, rf_r_w, rf_sel);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({rf_enb, rf_r_w, rf_sel, rf_wdata} !== {1'b1, 1'b0, 4'd1, 8'h99}) begin
      errors++;
      $display("FAIL swap_e3: enb=%0b rw=%0b sel=%h wd=%h required 1 0 1 99",
               rf_enb, rf_r_w, rf_sel, rf_wdata);
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0 || rf_mem[1] !== 8'h99 || rf_sel !== 4'd9 || rf_wdata !== 8'h01) begin
      errors++;
      $display("FAIL swap_e4: rdy=%0b r1=%h sel=%h wd=%h required 0 99 9 01",
               cmd_ready, rf_mem[1], rf_sel, rf_wdata);
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || rf_mem[9] !== 8'h01) begin
      errors++;
      $display("FAIL swap_e5: rdy=%0b r9=%h required 1 01", cmd_ready, rf_mem[9]);
    end
    t = model[1]; model[1] = model[9]; model[9] = t;
    do_write(4'd3, 8'hC3);
    issue(OP_SWAP, 4'd3, 4'd3, 8'h00);
    wait_idle("swap_same");
    checks++;
    if (rf_mem[3] !== 8'hC3) begin
      errors++;
      $display("FAIL swap_same: r3=%h required c3", rf_mem[3]);
    end
`else
    t = 8'h00;
    exp_err++;
    checks++;
    if (err !== 1'b1 || cmd_ready !== 1'b1 || rf_enb !== 1'b0) begin
      errors++;
      $display("FAIL swap_off_e0: err=%0b rdy=%0b enb=%0b required 1 1 0", err, cmd_ready, rf_enb);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || enb_cnt !== e || rf_mem[1] !== 8'h01 || rf_mem[9] !== 8'h99 || t !== 8'h00) begin
      errors++;
      $display("FAIL swap_off_e1: err=%0b enb_cycles=%0d r1=%h r9=%h required 0 %0d 01 99",
               err, enb_cnt, rf_mem[1], rf_mem[9], e);
    end
`endif
  endtask

  task automatic test_reset_mid();
    issue(OP_READ, 4'd5, 4'd0, 8'h00);
    repeat (2) @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_read_pre: rsp_valid=%0b required 1", rsp_valid);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || rf_enb !== 1'b0) begin
      errors++;
      $display("FAIL rst_read: rsp_valid=%0b rdy=%0b enb=%0b required 0 1 0", rsp_valid, cmd_ready, rf_enb);
    end
    rst_n = 1'b1;
`ifdef RF_MASTER_SWAP_EN
    do_write(4'd1, 8'h01);
    do_write(4'd9, 8'h99);
    issue(OP_SWAP, 4'd1, 4'd9, 8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (rf_enb !== 1'b0 || cmd_ready !== 1'b1 || rf_mem[1] !== 8'h99) begin
      errors++;
      $display("FAIL rst_swap: enb=%0b rdy=%0b r1=%h required 0 1 99", rf_enb, cmd_ready, rf_mem[1]);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    model[1] = model[9];
    checks++;
    if (rf_mem[9] !== 8'h99 || rf_enb !== 1'b0) begin
      errors++;
      $display("FAIL rst_swap_b: r9=%h enb=%0b required 99 0", rf_mem[9], rf_enb);
    end
`endif
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [1:0] op;
    logic [3:0] dst, src;
    logic [7:0] imm, t;
    for (int i = 0; i < 40; i++) begin
      op  = 2'($urandom_range(0, 3));
      dst = 4'($urandom_range(0, 15));
      src = 4'($urandom_range(0, 15));
      imm = 8'($urandom_range(0, 255));
      case (op)
        OP_WRITE: model[dst] = imm;
        OP_READ:  exp_q.push_back(model[dst]);
        OP_COPY:  model[dst] = model[src];
        default: begin
`ifdef RF_MASTER_SWAP_EN
          t = model[dst]; model[dst] = model[src]; model[src] = t;
`else
          t = 8'h00;
          exp_err++;
`endif
        end
      endcase
      issue(op, dst, src, imm);
      if (op == OP_READ) get_rsp($urandom_range(0, 3), "rand_read");
      else wait_idle("rand");
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    test_reset();
    test_write();
    test_read_backpressure();
    test_copy();
    test_swap();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rf_mem[i] !== model[i]) begin
        errors++;
        $display("FAIL final_reg%0d: value=%h required %h", i, rf_mem[i], model[i]);
      end
    end
    checks++;
    if (err_cnt !== exp_err) begin
      errors++;
      $display("FAIL err_count: pulses=%0d required %0d", err_cnt, exp_err);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
